hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised pipeline hazard controller; replaces the constant-0 flush/freeze ties in the ARM top.
//  Tracks every in-flight writer between ID and register-file write in a DEPTH-slot shift scoreboard.
//  Compares the ID stage's source registers against it; drives freeze (stall IF/ID, bubble into EXE) and flush.
//  With forwarding built in, also drives per-operand bypass selects and stalls only on load-use.
// PARAMETERS
//  REG_W   4   register index width (16 GPRs)
//  DEPTH   2   slots after ID whose result is not yet readable from reg file (slot0=EXE, slot1=MEM, ...)
//  CNT_W   16  stall-counter width
//  SEL_W   $clog2(DEPTH+1)  forward-select width (localparam)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous reset, active-high
//  id_valid      in   1      ID holds a real (non-bubble) instruction
//  id_src1       in   REG_W  Rn index
//  id_src1_used  in   1      instruction reads Rn
//  id_src2       in   REG_W  Rm / Rd-for-store index
//  id_src2_used  in   1      instruction reads src2
//  id_wb_en      in   1      ID instruction writes a register
//  id_mem_r_en   in   1      ID instruction is a load
//  id_dest       in   REG_W  ID destination index
//  branch_taken  in   1      branch resolved taken in EXE this cycle
//  freeze        out  1      hold PC and IF/ID reg; ID/EX reg loads a bubble
//  flush         out  1      squash IF/ID and ID/EX contents
//  fwd_sel1      out  SEL_W  src1 source: 0=reg file, k=slot k-1 result
//  fwd_sel2      out  SEL_W  src2 source, same encoding
//  stall_cnt     out  CNT_W  cycles with freeze=1 since reset, saturating
// BEHAVIOUR
//  - Slot k holds {v, wb, ld, dest}. Each clk: slot[k] <= slot[k-1] for k>=1.
//    slot[0] <= ID instr if id_valid & !freeze & !flush, else bubble (v=0).
//  - hit(s,k) = id_valid & src_used & slot[k].v & slot[k].wb & slot[k].dest==src. All 16 regs incl. r15 compared.
//  - flush = branch_taken (comb); flush forces freeze=0 (ID instr discarded anyway); flush wins over any hazard.
//  - freeze comb from current slots + ID inputs; no added latency; ID instr re-evaluated every stalled cycle.
//  - Slots advance during freeze; bubble enters slot0, so a RAW stall lasts at most DEPTH cycles.
//  - Reset: all slots v=0, stall_cnt=0; freeze=flush=0, fwd_sel*=0 while rst=1 (outputs gated by rst).
//  - stall_cnt +1 per cycle freeze=1; holds at 2^CNT_W-1 (no wrap); cleared only by rst.
//  - Reset mid-stall: next cycle all slots empty, freeze=0, ID proceeds.
//  - Same dest in several slots: youngest (lowest k) is the live value.
// CONFIGURATION
//  FORWARDING_EN defined:
//   - freeze = !flush & (hit(src1,0)|hit(src2,0)) & slot[0].ld  (load-use only).
//   - fwd_selN = 1+lowest k with hit(srcN,k), else 0; forced 0 when freeze or flush.
//  FORWARDING_EN undefined:
//   - freeze = !flush & OR over all k of hit(src1,k)|hit(src2,k).
//   - fwd_sel1 = fwd_sel2 = 0 constant.
// TESTING
//  1 rst high 3 cycles, random inputs -> freeze=flush=0, fwd=0, stall_cnt=0; first cycle after: slots empty.
//  2 ADD r1 then SUB r2,r1,r3 back-to-back, no FWD -> freeze=1 for 2 cycles, stall_cnt=2; with FWD -> freeze=0, fwd_sel1=1.
//  3 with FWD: LDR r4 then ADD r5,r4,r4 -> freeze 1 cycle, then fwd_sel1=fwd_sel2=2, stall_cnt=1.
//  4 ADD r1 in EXE, ID reads r1, branch_taken=1 -> flush=1, freeze=0; next cycle slot0 bubble.
//  5 MOV r1,#1 then MOV r1,#2 then ADD r0,r1, FWD -> fwd_sel1=1 (youngest), not 2.
//  6 CNT_W=2, hold continuous hazard 6 cycles -> stall_cnt reaches 3 and holds.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline RAW hazard scoreboard with freeze/flush and optional bypass selects (FORWARDING_EN)
//
// Build option: define FORWARDING_EN to enable per-operand bypass selects and
// load-use-only stalling. Without it, any in-flight writer of a source register
// freezes ID until the writer has reached the register file.
//
// Slot k describes the instruction k+1 stages past ID (slot0 = EXE, slot1 = MEM).
// A slot is {v, wb, ld, dest}; bubbles have v=0.

module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic             id_src1_used,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src2_used,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             branch_taken,
  output logic             freeze,
  output logic             flush,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt
);

  // Scoreboard slot state
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] wb_q, wb_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [REG_W-1:0] dest_q [DEPTH];
  logic [REG_W-1:0] dest_d [DEPTH];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Per-slot match of each ID source against an in-flight writer
  logic [DEPTH-1:0] hit1, hit2;

  // Ungated control; outputs are masked by rst below
  logic             freeze_raw;
  logic             flush_raw;
  logic [SEL_W-1:0] sel1_raw, sel2_raw;

  // The load flag of older slots only matters with forwarding; keep every bit observed
  logic unused_ld;
  assign unused_ld = ^ld_q;

  // Compare both ID sources against every live writing slot (r15 included)
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit1[k] = id_valid & id_src1_used & v_q[k] & wb_q[k] & (dest_q[k] == id_src1);
      hit2[k] = id_valid & id_src2_used & v_q[k] & wb_q[k] & (dest_q[k] == id_src2);
    end
  end

  // Hazard resolution: a taken branch squashes ID, so it overrides any stall
  always_comb begin
    flush_raw = branch_taken;
    sel1_raw  = '0;
    sel2_raw  = '0;
`ifdef FORWARDING_EN
    // Only a load in EXE cannot be bypassed in time
    freeze_raw = !flush_raw & (hit1[0] | hit2[0]) & ld_q[0];
    // Walk oldest to youngest so the youngest matching writer wins
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit1[k]) sel1_raw = SEL_W'(k + 1);
      if (hit2[k]) sel2_raw = SEL_W'(k + 1);
    end
    if (freeze_raw || flush_raw) begin
      sel1_raw = '0;
      sel2_raw = '0;
    end
`else
    freeze_raw = !flush_raw & ((|hit1) | (|hit2));
`endif
  end

  // Slot shift: ID enters slot0 only when it actually issues, otherwise a bubble
  always_comb begin
    v_d[0]    = id_valid & !freeze_raw & !flush_raw;
    wb_d[0]   = id_wb_en;
    ld_d[0]   = id_mem_r_en;
    dest_d[0] = id_dest;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]    = v_q[k-1];
      wb_d[k]   = wb_q[k-1];
      ld_d[k]   = ld_q[k-1];
      dest_d[k] = dest_q[k-1];
    end
  end

  // Saturating count of frozen cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze_raw && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      wb_q        <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k] <= '0;
      end
    end else begin
      v_q         <= v_d;
      wb_q        <= wb_d;
      ld_q        <= ld_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k] <= dest_d[k];
      end
    end
  end

  // Outputs held quiet while reset is asserted
  always_comb begin
    freeze    = !rst & freeze_raw;
    flush     = !rst & flush_raw;
    fwd_sel1  = rst ? '0 : sel1_raw;
    fwd_sel2  = rst ? '0 : sel2_raw;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table vectors plus random stimulus against an in-order pipeline model

module tb_hazard_scoreboard;

  localparam int REG_W = 4;
  localparam int DEPTH = 2;
  localparam int SEL_W = 2;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_src1 = '0;
  logic             id_src1_used = 1'b0;
  logic [REG_W-1:0] id_src2 = '0;
  logic             id_src2_used = 1'b0;
  logic             id_wb_en = 1'b0;
  logic             id_mem_r_en = 1'b0;
  logic [REG_W-1:0] id_dest = '0;
  logic             branch_taken = 1'b0;

  logic             freeze, flush, freeze_c, flush_c;
  logic [SEL_W-1:0] fwd_sel1, fwd_sel2, fwd_sel1_c, fwd_sel2_c;
  logic [15:0]      stall_cnt;
  logic [1:0]       stall_cnt_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .freeze(freeze), .flush(flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .freeze(freeze_c), .flush(flush_c),
    .fwd_sel1(fwd_sel1_c), .fwd_sel2(fwd_sel2_c), .stall_cnt(stall_cnt_c)
  );

  // Reference model: queue of in-flight instructions, youngest at index 0
  typedef struct {
    bit       v;
    bit       wb;
    bit       ld;
    bit [3:0] dest;
  } ent_t;

  ent_t        pipe[$];
  int unsigned m_cnt = 0;
  bit          e_fz, e_fl;
  int          e_s1, e_s2;

  typedef struct {
    bit v; bit [3:0] s1; bit u1; bit [3:0] s2; bit u2;
    bit wb; bit ld; bit [3:0] d; bit br;
    bit fz_nf; bit fz_f; bit fl; int s1_f; int s2_f; int cnt_nf; int cnt_f;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int youngest(input logic [3:0] src);
    int found = -1;
    for (int k = pipe.size() - 1; k >= 0; k--) begin
      if (pipe[k].v && pipe[k].wb && pipe[k].dest == src) found = k;
    end
    return found;
  endfunction

  function automatic void model_eval();
    int h1, h2;
    e_fz = 0; e_fl = 0; e_s1 = 0; e_s2 = 0;
    if (!rst) begin
      h1 = (id_valid && id_src1_used) ? youngest(id_src1) : -1;
      h2 = (id_valid && id_src2_used) ? youngest(id_src2) : -1;
      e_fl = branch_taken;
      if (FWD) begin
        e_fz = !e_fl && pipe[0].ld && (h1 == 0 || h2 == 0);
        e_s1 = (e_fz || e_fl || h1 < 0) ? 0 : h1 + 1;
        e_s2 = (e_fz || e_fl || h2 < 0) ? 0 : h2 + 1;
      end else begin
        e_fz = !e_fl && (h1 >= 0 || h2 >= 0);
      end
    end
  endfunction

  function automatic void model_clock();
    ent_t e;
    if (rst) begin
      pipe = {};
      e = '{0, 0, 0, 4'd0};
      for (int k = 0; k < DEPTH; k++) pipe.push_back(e);
      m_cnt = 0;
    end else begin
      e.v = id_valid && !e_fz && !e_fl;
      e.wb = id_wb_en; e.ld = id_mem_r_en; e.dest = id_dest;
      pipe.push_front(e);
      void'(pipe.pop_back());
      if (e_fz && m_cnt < 65535) m_cnt++;
    end
  endfunction

  // Compare every output against the model, then advance the model with the clock
  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, ".freeze"}, freeze, e_fz);
    chk({tag, ".flush"}, flush, e_fl);
    chk({tag, ".sel1"}, fwd_sel1, e_s1);
    chk({tag, ".sel2"}, fwd_sel2, e_s2);
    chk({tag, ".cnt"}, stall_cnt, m_cnt);
    chk({tag, ".freeze_c"}, freeze_c, e_fz);
    chk({tag, ".cnt_c"}, stall_cnt_c, (m_cnt > 3) ? 3 : m_cnt);
    @(posedge clk);
    model_clock();
  endtask

  task automatic apply(input bit r, input bit v, input bit [3:0] s1, input bit u1,
                       input bit [3:0] s2, input bit u2, input bit wb, input bit ld,
                       input bit [3:0] d, input bit br, input string tag);
    @(negedge clk);
    rst = r; id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2;
    id_src2_used = u2; id_wb_en = wb; id_mem_r_en = ld; id_dest = d; branch_taken = br;
    step(tag);
  endtask

  function automatic vec_t mk(input bit v, input bit [3:0] s1, input bit u1,
                              input bit [3:0] s2, input bit u2, input bit wb, input bit ld,
                              input bit [3:0] d, input bit br, input bit fz_nf, input bit fz_f,
                              input bit fl, input int s1_f, input int s2_f,
                              input int cnt_nf, input int cnt_f);
    vec_t t;
    t.v = v; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2; t.wb = wb; t.ld = ld;
    t.d = d; t.br = br; t.fz_nf = fz_nf; t.fz_f = fz_f; t.fl = fl;
    t.s1_f = s1_f; t.s2_f = s2_f; t.cnt_nf = cnt_nf; t.cnt_f = cnt_f;
    return t;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t bub;
    bit   stuck;
    bub = '{0, 0, 0, 4'd0};
    for (int k = 0; k < DEPTH; k++) pipe.push_back(bub);

    // Reset held for three cycles under random ID inputs
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 4'($urandom), 1, 4'($urandom), 1, 1, 1'($urandom), 4'($urandom), 1'($urandom), "rst");
      chk("rst_freeze", freeze, 0);
      chk("rst_flush", flush, 0);
      chk("rst_sel", {fwd_sel1, fwd_sel2}, 0);
      chk("rst_cnt", stall_cnt, 0);
    end

    // Directed sequence: RAW chain, load-use, flush, youngest writer, valid/used gating, r15
    tbl[0]  = mk(1, 2, 1, 3, 1, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 3, 1, 1, 0, 2, 0,  1, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 3, 1, 1, 0, 2, 0,  1, 0, 0, 2, 0, 1, 0);
    tbl[3]  = mk(1, 1, 1, 3, 1, 1, 0, 2, 0,  0, 0, 0, 0, 0, 2, 0);
    tbl[4]  = mk(1, 6, 1, 0, 0, 1, 1, 4, 0,  0, 0, 0, 0, 0, 2, 0);
    tbl[5]  = mk(1, 4, 1, 4, 1, 1, 0, 5, 0,  1, 1, 0, 0, 0, 2, 0);
    tbl[6]  = mk(1, 4, 1, 4, 1, 1, 0, 5, 0,  1, 0, 0, 2, 2, 3, 1);
    tbl[7]  = mk(1, 5, 1, 0, 0, 1, 0, 7, 1,  0, 0, 1, 0, 0, 4, 1);
    tbl[8]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 4, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 4, 1);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 4, 1);
    tbl[11] = mk(1, 1, 1, 9, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 4, 1);
    tbl[12] = mk(0, 1, 1, 1, 1, 1, 0, 3, 0,  0, 0, 0, 0, 0, 5, 1);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 0, 15, 0, 0, 0, 0, 0, 0, 5, 1);
    tbl[14] = mk(1, 15, 0, 15, 1, 1, 0, 6, 0, 1, 0, 0, 0, 1, 5, 1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst = 0; id_valid = tbl[i].v; id_src1 = tbl[i].s1; id_src1_used = tbl[i].u1;
      id_src2 = tbl[i].s2; id_src2_used = tbl[i].u2; id_wb_en = tbl[i].wb;
      id_mem_r_en = tbl[i].ld; id_dest = tbl[i].d; branch_taken = tbl[i].br;
      #1;
      chk($sformatf("vec%0d.freeze", i), freeze, FWD ? tbl[i].fz_f : tbl[i].fz_nf);
      chk($sformatf("vec%0d.flush", i), flush, tbl[i].fl);
      chk($sformatf("vec%0d.sel1", i), fwd_sel1, FWD ? tbl[i].s1_f : 0);
      chk($sformatf("vec%0d.sel2", i), fwd_sel2, FWD ? tbl[i].s2_f : 0);
      chk($sformatf("vec%0d.cnt", i), stall_cnt, FWD ? tbl[i].cnt_f : tbl[i].cnt_nf);
      step($sformatf("vec%0d", i));
    end

    // Reset in the middle of a stall: the next cycle must see an empty scoreboard
    apply(0, 1, 0, 0, 0, 0, 1, 1, 8, 0, "mid_w");
    apply(0, 1, 8, 1, 8, 1, 1, 0, 9, 0, "mid_r");
    apply(1, 1, 8, 1, 8, 1, 1, 0, 9, 0, "mid_rst");
    apply(0, 1, 8, 1, 8, 1, 1, 0, 9, 0, "mid_after");
    chk("mid_after_freeze", freeze, 0);

    // Random traffic over a small register window to provoke frequent hazards
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
            1'($urandom),
            ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
            1'($urandom),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0),
            "rnd");
    end

    // Saturation of the narrow counter under repeated load-use stalls
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_rst");
    for (int rep = 0; rep < 6; rep++) begin
      apply(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, "sat_w");
      stuck = 1;
      for (int j = 0; j < 6; j++) begin
        apply(0, 1, 1, 1, 2, 0, 1, 0, 3, 0, "sat_r");
        if (!e_fz) begin
          stuck = 0;
          break;
        end
      end
      chk("sat_stall_bound", stuck, 0);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_idle");
    chk("sat_cnt_c", stall_cnt_c, 3);
    chk("sat_cnt_wide", stall_cnt, FWD ? 6 : 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
